// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control and control-register file
// MEM-stage commit of interrupts, exceptions, EXRT and WRCR; fetch redirect via new_pc.
module pipe_ctrl #(
   parameter logic [29:0] EXP_VECTOR_INIT = 30'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic        ld_hazard,
   input  logic [7:0]  irq,
   input  logic [4:0]  creg_rd_addr,
   output logic [31:0] creg_rd_data,
   input  logic        mem_en,
   input  logic [29:0] mem_pc,
   input  logic [2:0]  mem_exp_code,
   input  logic [1:0]  mem_ctrl_op,
   input  logic [4:0]  mem_dst_addr,
   input  logic [31:0] mem_out,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        mem_flush,
   output logic [29:0] new_pc,
   output logic        exe_mode,
   output logic        int_en
);

   localparam logic [1:0] OP_WRCR = 2'd1;
   localparam logic [1:0] OP_EXRT = 2'd2;

   localparam logic [4:0] A_STATUS     = 5'd0;
   localparam logic [4:0] A_PRE_STATUS = 5'd1;
   localparam logic [4:0] A_EPC        = 5'd2;
   localparam logic [4:0] A_EXP_VECTOR = 5'd3;
   localparam logic [4:0] A_CAUSE      = 5'd4;
   localparam logic [4:0] A_INT_MASK   = 5'd5;
   localparam logic [4:0] A_IRQ        = 5'd6;

   logic [1:0]  status_q, status_d;
   logic [1:0]  pre_status_q, pre_status_d;
   logic [29:0] epc_q, epc_d;
   logic [29:0] exp_vector_q, exp_vector_d;
   logic [2:0]  cause_q, cause_d;
   logic [7:0]  int_mask_q, int_mask_d;

   logic        stall;
   logic        commit;
   logic        int_pending;
   logic        take_int;
   logic        take_exc;
   logic        take_trap;
   logic        take_exrt;
   logic        take_wrcr;
   logic        redirect;
   logic [2:0]  trap_code;

   // Commit decode: interrupt beats exception beats EXRT beats WRCR.
   always_comb begin
      stall       = if_busy | mem_busy;
      commit      = mem_en & ~stall;
      int_pending = status_q[1] & (|(irq & ~int_mask_q));
      take_int    = commit & int_pending;
      take_exc    = commit & ~int_pending & (mem_exp_code != 3'd0);
      take_trap   = take_int | take_exc;
      take_exrt   = commit & ~take_trap & (mem_ctrl_op == OP_EXRT);
      take_wrcr   = commit & ~take_trap & (mem_ctrl_op == OP_WRCR);
      redirect    = take_trap | take_exrt;
      trap_code   = take_int ? 3'd1 : mem_exp_code;
   end

   always_comb begin
      if_stall  = stall | ld_hazard;
      id_stall  = stall;
      ex_stall  = stall;
      mem_stall = stall;
      if_flush  = redirect;
      id_flush  = redirect | (ld_hazard & ~stall);
      ex_flush  = redirect;
      mem_flush = redirect;
      new_pc    = 30'h0;
      if (take_trap) begin
         new_pc = exp_vector_q;
      end else if (take_exrt) begin
         new_pc = epc_q;
      end
   end

   always_comb begin
      status_d     = status_q;
      pre_status_d = pre_status_q;
      epc_d        = epc_q;
      exp_vector_d = exp_vector_q;
      cause_d      = cause_q;
      int_mask_d   = int_mask_q;
      if (take_trap) begin
         epc_d        = mem_pc;
         pre_status_d = status_q;
         status_d     = 2'b00;
         cause_d      = trap_code;
      end else if (take_exrt) begin
         status_d = pre_status_q;
      end else if (take_wrcr) begin
         // IRQ and unmapped addresses fall through to default and are dropped.
         case (mem_dst_addr)
            A_STATUS:     status_d     = mem_out[1:0];
            A_PRE_STATUS: pre_status_d = mem_out[1:0];
            A_EPC:        epc_d        = mem_out[31:2];
            A_EXP_VECTOR: exp_vector_d = mem_out[31:2];
            A_CAUSE:      cause_d      = mem_out[2:0];
            A_INT_MASK:   int_mask_d   = mem_out[7:0];
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         status_q     <= 2'b00;
         pre_status_q <= 2'b00;
         epc_q        <= 30'h0;
         exp_vector_q <= EXP_VECTOR_INIT;
         cause_q      <= 3'd0;
         int_mask_q   <= 8'hFF;
      end else begin
         status_q     <= status_d;
         pre_status_q <= pre_status_d;
         epc_q        <= epc_d;
         exp_vector_q <= exp_vector_d;
         cause_q      <= cause_d;
         int_mask_q   <= int_mask_d;
      end
   end

   always_comb begin
      creg_rd_data = 32'h0;
      case (creg_rd_addr)
         A_STATUS:     creg_rd_data = {30'h0, status_q};
         A_PRE_STATUS: creg_rd_data = {30'h0, pre_status_q};
         A_EPC:        creg_rd_data = {epc_q, 2'b00};
         A_EXP_VECTOR: creg_rd_data = {exp_vector_q, 2'b00};
         A_CAUSE:      creg_rd_data = {29'h0, cause_q};
         A_INT_MASK:   creg_rd_data = {24'h0, int_mask_q};
         A_IRQ:        creg_rd_data = {24'h0, irq};
         default:      creg_rd_data = 32'h0;
      endcase
   end

   assign exe_mode = status_q[0];
   assign int_en   = status_q[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   localparam logic [29:0] INIT = 30'h123;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_busy, mem_busy, ld_hazard;
   logic [7:0]  irq;
   logic [4:0]  creg_rd_addr;
   logic [31:0] creg_rd_data;
   logic        mem_en;
   logic [29:0] mem_pc;
   logic [2:0]  mem_exp_code;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [31:0] mem_out;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic [29:0] new_pc;
   logic        exe_mode, int_en;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference state: one 32-bit word per register address, as the decoder sees it.
   logic [31:0] m_reg [0:31];
   logic [31:0] wmask [0:31];

   pipe_ctrl #(.EXP_VECTOR_INIT(INIT)) dut (
      .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
      .ld_hazard(ld_hazard), .irq(irq), .creg_rd_addr(creg_rd_addr),
      .creg_rd_data(creg_rd_data), .mem_en(mem_en), .mem_pc(mem_pc),
      .mem_exp_code(mem_exp_code), .mem_ctrl_op(mem_ctrl_op),
      .mem_dst_addr(mem_dst_addr), .mem_out(mem_out),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
      .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
      .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
      .exe_mode(exe_mode), .int_en(int_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_reg[3] = {INIT, 2'b00};
      m_reg[5] = 32'hFF;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic [7:0] iv);
      if (a == 5'd6) return {24'h0, iv};
      return m_reg[a];
   endfunction

   task automatic step(input logic ib, input logic mb, input logic lh, input logic en,
                       input logic [2:0] ec, input logic [1:0] op, input logic [4:0] dst,
                       input logic [31:0] wd, input logic [29:0] pc, input logic [7:0] iv,
                       input logic [4:0] ra);
      logic        stall, commit, int_req, redirect;
      logic [2:0]  code;
      logic [29:0] tgt;
      @(negedge clk);
      if_busy = ib; mem_busy = mb; ld_hazard = lh; mem_en = en;
      mem_exp_code = ec; mem_ctrl_op = op; mem_dst_addr = dst; mem_out = wd;
      mem_pc = pc; irq = iv; creg_rd_addr = ra;
      #1;
      stall    = ib | mb;
      commit   = en & ~stall;
      int_req  = m_reg[0][1] && ((iv & ~m_reg[5][7:0]) != 8'h0);
      code     = int_req ? 3'd1 : ec;
      redirect = 1'b0;
      tgt      = 30'h0;
      if (commit && code != 3'd0) begin
         redirect = 1'b1; tgt = m_reg[3][31:2];
      end else if (commit && op == 2'd2) begin
         redirect = 1'b1; tgt = m_reg[2][31:2];
      end
      check("stalls", {28'h0, if_stall, id_stall, ex_stall, mem_stall},
            {28'h0, stall | lh, stall, stall, stall});
      check("flushes", {28'h0, if_flush, id_flush, ex_flush, mem_flush},
            {28'h0, redirect, redirect | (lh & ~stall), redirect, redirect});
      check("new_pc", {2'b00, new_pc}, {2'b00, tgt});
      check("mode", {30'h0, int_en, exe_mode}, {30'h0, m_reg[0][1:0]});
      check("creg_rd", creg_rd_data, model_read(ra, iv));
      if (commit) begin
         if (code != 3'd0) begin
            m_reg[2] = {pc, 2'b00};
            m_reg[1] = m_reg[0];
            m_reg[0] = 32'h0;
            m_reg[4] = {29'h0, code};
         end else if (op == 2'd2) begin
            m_reg[0] = m_reg[1];
         end else if (op == 2'd1) begin
            m_reg[dst] = wd & wmask[dst];
         end
      end
   endtask

   task automatic wrcr(input logic [4:0] dst, input logic [31:0] wd);
      step(0, 0, 0, 1, 3'd0, 2'd1, dst, wd, 30'h3F0, 8'h00, dst);
   endtask

   task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
      @(negedge clk);
      if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; creg_rd_addr = a;
      #1;
      check(tag, creg_rd_data, exp);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) wmask[i] = 32'h0;
      wmask[0] = 32'h3; wmask[1] = 32'h3; wmask[2] = 32'hFFFF_FFFC;
      wmask[3] = 32'hFFFF_FFFC; wmask[4] = 32'h7; wmask[5] = 32'hFF;
      reset = 0; if_busy = 0; mem_busy = 0; ld_hazard = 0; irq = 0; creg_rd_addr = 0;
      mem_en = 0; mem_pc = 0; mem_exp_code = 0; mem_ctrl_op = 0; mem_dst_addr = 0; mem_out = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1;

      rd_check("rst_exp_vector", 5'd3, {INIT, 2'b00});
      rd_check("rst_int_mask", 5'd5, 32'hFF);
      rd_check("rst_status", 5'd0, 32'h0);
      step(0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 30'h0, 8'h00, 5'd4);

      step(0, 0, 1, 0, 3'd0, 2'd0, 5'd0, 32'h0, 30'h0, 8'h00, 5'd0);
      check("ld_if_stall", {31'h0, if_stall}, 32'h1);
      check("ld_id_flush", {31'h0, id_flush}, 32'h1);
      check("ld_id_stall", {31'h0, id_stall}, 32'h0);
      step(0, 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'h0, 30'h0, 8'h00, 5'd0);
      check("ldb_stalls", {28'h0, if_stall, id_stall, ex_stall, mem_stall}, 32'hF);
      check("ldb_id_flush", {31'h0, id_flush}, 32'h0);

      wrcr(5'd0, 32'h1);
      step(0, 0, 0, 1, 3'd2, 2'd0, 5'd0, 32'h0, 30'h100, 8'h00, 5'd0);
      check("exc_flushes", {28'h0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
      check("exc_new_pc", {2'b00, new_pc}, {2'b00, INIT});
      rd_check("exc_epc", 5'd2, 32'h400);
      rd_check("exc_cause", 5'd4, 32'h2);
      rd_check("exc_status", 5'd0, 32'h0);
      rd_check("exc_pre_status", 5'd1, 32'h1);

      wrcr(5'd5, 32'hFE);
      wrcr(5'd0, 32'h2);
      step(0, 0, 0, 1, 3'd3, 2'd0, 5'd0, 32'h0, 30'h104, 8'h01, 5'd4);
      rd_check("int_wins_cause", 5'd4, 32'h1);
      wrcr(5'd0, 32'h2);
      wrcr(5'd5, 32'hFF);
      step(0, 0, 0, 1, 3'd3, 2'd0, 5'd0, 32'h0, 30'h108, 8'h01, 5'd4);
      rd_check("masked_exc_cause", 5'd4, 32'h3);

      wrcr(5'd2, 32'h400);
      wrcr(5'd1, 32'h3);
      step(0, 0, 0, 1, 3'd0, 2'd2, 5'd0, 32'h0, 30'h10C, 8'h00, 5'd0);
      check("exrt_new_pc", {2'b00, new_pc}, 32'h100);
      check("exrt_flushes", {28'h0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
      step(0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 30'h0, 8'h00, 5'd0);
      check("exrt_mode", {30'h0, int_en, exe_mode}, 32'h3);
      rd_check("exrt_status", 5'd0, 32'h3);

      wrcr(5'd5, 32'hFE);
      wrcr(5'd1, 32'h2);
      step(0, 0, 0, 1, 3'd0, 2'd2, 5'd0, 32'h0, 30'h110, 8'h00, 5'd0);
      step(0, 0, 0, 1, 3'd0, 2'd0, 5'd0, 32'h0, 30'h200, 8'h01, 5'd0);
      rd_check("b2b_epc", 5'd2, 32'h800);
      rd_check("b2b_cause", 5'd4, 32'h1);

      irq = 8'h00;
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 1, 3'd0, 2'd1, 5'd5, 32'h0F, 30'h300, 8'h00, 5'd5);
      rd_check("stall_mask_held", 5'd5, 32'hFE);
      step(0, 0, 0, 1, 3'd0, 2'd1, 5'd5, 32'h0F, 30'h300, 8'h00, 5'd5);
      rd_check("stall_mask_written", 5'd5, 32'h0F);
      step(0, 0, 0, 1, 3'd0, 2'd1, 5'd6, 32'hFFFF, 30'h304, 8'h5A, 5'd6);
      rd_check("irq_readonly", 5'd6, 32'h5A);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
              $urandom, 30'($urandom),
              ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
              ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
         if (i == 200) begin
            @(negedge clk);
            if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 1; mem_exp_code = 3'd2;
            mem_ctrl_op = 2'd0; irq = 8'h00; creg_rd_addr = 5'd5; reset = 0;
            #1;
            model_reset();
            check("midrst_mask", creg_rd_data, 32'hFF);
            check("midrst_mode", {30'h0, int_en, exe_mode}, 32'h0);
            check("midrst_flushes", {28'h0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
            check("midrst_new_pc", {2'b00, new_pc}, {2'b00, INIT});
            #1;
            mem_en = 0;
            reset = 1;
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
